instr_fetch: RTL and testbench

Instruction fetch stage for the RV32I core. It holds the program counter and drives the synchronous instruction ROM's enable and byte address. It captures each returned word one cycle after the request and delivers {pc, instruction} pairs to decode over a valid/ready handshake. Branch and jump redirects discard everything still in flight. A 2-entry buffer absorbs decode back-pressure, so instructions are never dropped.

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/fetch_buf.sv | 84 ++++++++
 rtl/instr_fetch.sv | 108 ++++++++++
 tb/tb_instr_fetch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared constants, fetch-entry type and alignment helper for
//               the RV32I core front end.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Instruction addresses must sit on a 4-byte boundary.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf
// Description : Two-entry synchronous FIFO of {pc, inst} pairs with flush.
//               Flush takes priority over push and pop in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
  import rv32i_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o,
  output logic         empty_o
);

  localparam logic [1:0] DEPTH = 2'd2;

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push;
  logic         do_pop;

  // Guard against pushing into a full buffer or popping an empty one.
  always_comb begin
    do_push = push_i & (count_q != DEPTH);
    do_pop  = pop_i & (count_q != 2'd0);
  end

  // Next-state: flush empties the buffer, otherwise push/pop update pointers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage and pointer registers; entries clear to zero so the head reads 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);

endmodule : fetch_buf
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : RV32I instruction fetch stage. Holds the pc, issues reads to
//               a registered instruction ROM, tags each returning word with
//               its pc and buffers up to two results for decode. Redirects
//               discard everything in flight; a misaligned redirect target
//               raises a sticky error that halts fetching until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic            rom_en_o,
  output logic [XLEN-1:0] rom_addr_o,
  input  logic [XLEN-1:0] rom_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_err_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tag_q, tag_d;
  logic            inflight_q, inflight_d;
  logic            err_q, err_d;

  fetch_entry_t    buf_head;
  fetch_entry_t    buf_push_data;
  logic [1:0]      buf_count;
  logic            buf_empty;
  logic            buf_push;
  logic            pop;
  logic            issue;
  logic            bad_redirect;
  logic [2:0]      occupancy;

  // Handshake, credit check and issue decision for this cycle.
  always_comb begin
    pop          = ~buf_empty & ~err_q & inst_ready_i;
    // Slots committed after this cycle's pop: buffered plus the word on its way.
    occupancy    = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
    issue        = (occupancy < 3'd2) & ~redirect_i & ~err_q & rst_n_i;
    bad_redirect = redirect_i & ~is_aligned(redirect_pc_i);
    // A redirect kills the returning word as well as everything buffered.
    buf_push     = inflight_q & ~redirect_i;
    buf_push_data = '{pc: tag_q, inst: rom_data_i};
  end

  // Next pc, in-flight tag and sticky error.
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    err_d      = err_q | bad_redirect;
    if (issue) begin
      pc_d  = pc_q + INST_BYTES;
      tag_d = pc_q;
    end
    // pc is loaded even for a misaligned target so it is visible for debug.
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end
  end

  // Fetch-control registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  fetch_buf u_fetch_buf (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (buf_push),
    .push_data_i (buf_push_data),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .head_o      (buf_head),
    .count_o     (buf_count),
    .empty_o     (buf_empty)
  );

  assign rom_en_o     = issue;
  assign rom_addr_o   = pc_q;
  assign inst_valid_o = ~buf_empty & ~err_q;
  assign inst_o       = buf_head.inst;
  assign pc_o         = buf_head.pc;
  assign fetch_err_o  = err_q;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. A registered ROM model
//               serves words from a hash of the address; a queue-based
//               reference tracks issued fetches in program order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
  import rv32i_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fetch_err;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } item_t;

  item_t       q[$];
  logic [31:0] fetch_pc = RESET_PC;
  logic        err_exp  = 1'b0;
  int          t        = 0;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .rom_en_o      (rom_en),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .inst_valid_o  (inst_valid),
    .inst_ready_i  (inst_ready),
    .inst_o        (inst),
    .pc_o          (pc),
    .fetch_err_o   (fetch_err)
  );

  always #5 clk = ~clk;

  // Program image: address 0 holds 32'h0010_0193.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0010_0193;
  endfunction

  // Registered ROM returning 0 when not enabled.
  always @(posedge clk) rom_data <= rom_en ? rom_fn(rom_addr) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    q.delete();
    fetch_pc = RESET_PC;
    err_exp  = 1'b0;
  endtask

  // One clock cycle: compare outputs at the falling edge, advance the model,
  // then return 1 time unit after the next rising edge.
  task automatic step();
    logic exp_valid;
    logic do_pop;
    logic exp_en;
    @(negedge clk);
    chk("fetch_err", 32'(fetch_err), 32'(err_exp));
    exp_valid = !err_exp && (q.size() > 0) && (q[0].cyc + 2 <= t);
    chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("pc_o", pc, q[0].pc);
      chk("inst_o", inst, rom_fn(q[0].pc));
    end
    do_pop = exp_valid && inst_ready;
    exp_en = !err_exp && !redirect && ((q.size() - (do_pop ? 1 : 0)) < 2);
    chk("rom_en", 32'(rom_en), 32'(exp_en));
    if (exp_en) chk("rom_addr", rom_addr, fetch_pc);
    if (do_pop) void'(q.pop_front());
    if (exp_en) begin
      q.push_back('{pc: fetch_pc, cyc: t});
      fetch_pc = fetch_pc + 32'd4;
    end
    if (redirect) begin
      q.delete();
      fetch_pc = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) err_exp = 1'b1;
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_err"}, 32'(fetch_err), 32'h0);
    chk({tag, "_rom_en"}, 32'(rom_en), 32'h0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();

    // Streaming with decode always ready; first instruction valid in cycle 2.
    inst_ready = 1'b1;
    repeat (2) step();
    chk("first_valid", 32'(inst_valid), 32'h1);
    chk("first_pc", pc, 32'h0);
    chk("first_inst", inst, 32'h0010_0193);
    repeat (6) step();

    // Back-pressure for 6 cycles, then release.
    inst_ready = 1'b0;
    repeat (6) step();
    chk("bp_rom_en_low", 32'(rom_en), 32'h0);
    inst_ready = 1'b1;
    repeat (8) step();

    // Redirect to 0x30 with the buffer full.
    inst_ready = 1'b0;
    repeat (4) step();
    redirect = 1'b1;
    redirect_pc = 32'h30;
    step();
    redirect = 1'b0;
    inst_ready = 1'b1;
    repeat (2) step();
    chk("redir_pc", pc, 32'h30);
    chk("redir_valid", 32'(inst_valid), 32'h1);
    repeat (4) step();

    // Redirect in the same cycle as a pop and a returning push.
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    repeat (6) step();

    // Wrap of the pc past the top of the address space.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    repeat (8) step();

    // Randomized ready and redirect traffic.
    for (int i = 0; i < 400; i++) begin
      inst_ready  = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 32'($urandom_range(0, 255)) << 2;
      step();
    end
    redirect = 1'b0;
    inst_ready = 1'b1;
    repeat (4) step();

    // Misaligned redirect: sticky error, no further fetches or output.
    redirect = 1'b1;
    redirect_pc = 32'h32;
    step();
    redirect = 1'b0;
    chk("mis_err", 32'(fetch_err), 32'h1);
    repeat (6) step();
    chk("mis_rom_en", 32'(rom_en), 32'h0);

    // Reset clears the error; fetch restarts at RESET_PC.
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("err_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (10) step();

    // Asynchronous reset mid-stream for one cycle.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (2) step();
    chk("restart_pc", pc, RESET_PC);
    chk("restart_valid", 32'(inst_valid), 32'h1);
    for (int i = 0; i < 40; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire
